// File: rtl/uart_echo_unit.sv
// 8N1 UART loopback: receiver, one-byte holding buffer and transmitter; counts accepted bytes.
// Define UART_ECHO_FRAME_CHECK_EN to discard frames whose stop bit samples low.
module uart_echo_unit #(
  parameter int unsigned clock_frequency = 12000000,
  parameter int unsigned baud_rate       = 9600
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic       tx,
  output logic [7:0] byte_cnt
);

  localparam int unsigned BIT_CLKS = clock_frequency / baud_rate;
  localparam int CNT_W = (BIT_CLKS > 2) ? $clog2(BIT_CLKS) : 1;
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CLKS - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BIT_CLKS / 2 - 1);

  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_e;
  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_e;

  logic             rx_meta_q, rx_sync_q, rx_prev_q;
  rx_state_e        rx_state_q;
  logic [CNT_W-1:0] rx_cnt_q;
  logic [2:0]       rx_bit_q;
  logic [7:0]       rx_shift_q;
  logic [7:0]       byte_cnt_q;

  logic [7:0]       buf_q;
  logic             buf_full_q;
  logic             buf_full_d;
  logic             buf_write_d;

  tx_state_e        tx_state_q;
  logic [CNT_W-1:0] tx_cnt_q;
  logic [2:0]       tx_bit_q;
  logic [7:0]       tx_shift_q;
  logic             tx_q;

  logic             rx_stop_ok;
  logic             rx_accept;
  logic             tx_load;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
    end
  end

`ifdef UART_ECHO_FRAME_CHECK_EN
  assign rx_stop_ok = rx_sync_q;
`else
  assign rx_stop_ok = 1'b1;
`endif

  assign rx_accept = (rx_state_q == RX_STOP) && (rx_cnt_q == '0) && rx_stop_ok;

  // Re-arming at mid-stop-bit lets a back-to-back start edge be caught; a line
  // still low after a bad stop bit produces no falling edge until it goes high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state_q <= RX_IDLE;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_shift_q <= '0;
      byte_cnt_q <= '0;
    end else begin
      if (rx_accept) byte_cnt_q <= byte_cnt_q + 8'd1;
      case (rx_state_q)
        RX_IDLE: begin
          if (rx_prev_q && !rx_sync_q) begin
            rx_state_q <= RX_START;
            rx_cnt_q   <= HALF_LAST;
          end
        end
        RX_START: begin
          if (rx_cnt_q == '0) begin
            if (rx_sync_q) begin
              rx_state_q <= RX_IDLE;
            end else begin
              rx_state_q <= RX_DATA;
              rx_cnt_q   <= BIT_LAST;
              rx_bit_q   <= '0;
            end
          end else begin
            rx_cnt_q <= rx_cnt_q - CNT_W'(1);
          end
        end
        RX_DATA: begin
          if (rx_cnt_q == '0) begin
            rx_shift_q <= {rx_sync_q, rx_shift_q[7:1]};
            rx_cnt_q   <= BIT_LAST;
            if (rx_bit_q == 3'd7) rx_state_q <= RX_STOP;
            else                  rx_bit_q   <= rx_bit_q + 3'd1;
          end else begin
            rx_cnt_q <= rx_cnt_q - CNT_W'(1);
          end
        end
        RX_STOP: begin
          if (rx_cnt_q == '0) rx_state_q <= RX_IDLE;
          else                rx_cnt_q   <= rx_cnt_q - CNT_W'(1);
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  assign tx_load = buf_full_q &&
                   ((tx_state_q == TX_IDLE) || ((tx_state_q == TX_STOP) && (tx_cnt_q == '0)));

  always_comb begin
    buf_write_d = rx_accept && (!buf_full_q || tx_load);
    buf_full_d  = buf_full_q;
    if (buf_write_d)  buf_full_d = 1'b1;
    else if (tx_load) buf_full_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      buf_q      <= '0;
      buf_full_q <= 1'b0;
    end else begin
      buf_full_q <= buf_full_d;
      if (buf_write_d) buf_q <= rx_shift_q;
    end
  end

  // The next start bit is launched straight out of the stop bit so back-to-back
  // echoes keep exactly the incoming frame rate.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state_q <= TX_IDLE;
      tx_cnt_q   <= '0;
      tx_bit_q   <= '0;
      tx_shift_q <= '0;
      tx_q       <= 1'b1;
    end else begin
      case (tx_state_q)
        TX_IDLE: begin
          if (tx_load) begin
            tx_shift_q <= buf_q;
            tx_q       <= 1'b0;
            tx_cnt_q   <= BIT_LAST;
            tx_state_q <= TX_START;
          end
        end
        TX_START: begin
          if (tx_cnt_q == '0) begin
            tx_q       <= tx_shift_q[0];
            tx_shift_q <= {1'b0, tx_shift_q[7:1]};
            tx_bit_q   <= '0;
            tx_cnt_q   <= BIT_LAST;
            tx_state_q <= TX_DATA;
          end else begin
            tx_cnt_q <= tx_cnt_q - CNT_W'(1);
          end
        end
        TX_DATA: begin
          if (tx_cnt_q == '0) begin
            tx_cnt_q <= BIT_LAST;
            if (tx_bit_q == 3'd7) begin
              tx_q       <= 1'b1;
              tx_state_q <= TX_STOP;
            end else begin
              tx_q       <= tx_shift_q[0];
              tx_shift_q <= {1'b0, tx_shift_q[7:1]};
              tx_bit_q   <= tx_bit_q + 3'd1;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q - CNT_W'(1);
          end
        end
        TX_STOP: begin
          if (tx_cnt_q == '0) begin
            if (tx_load) begin
              tx_shift_q <= buf_q;
              tx_q       <= 1'b0;
              tx_cnt_q   <= BIT_LAST;
              tx_state_q <= TX_START;
            end else begin
              tx_state_q <= TX_IDLE;
            end
          end else begin
            tx_cnt_q <= tx_cnt_q - CNT_W'(1);
          end
        end
        default: tx_state_q <= TX_IDLE;
      endcase
    end
  end

  assign tx       = tx_q;
  assign byte_cnt = byte_cnt_q;

endmodule

// File: tb/tb_uart_echo_unit.sv
// Directed bench for uart_echo_unit at 8 clocks per bit; a free-running tx
// decoder collects echoed bytes and their start cycles.
module tb_uart_echo_unit;

  localparam int CLK_HZ = 80;
  localparam int BAUD   = 10;
  localparam int B      = CLK_HZ / BAUD;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx;
  logic       tx;
  logic [7:0] byte_cnt;

  int         errors = 0;
  int         checks = 0;
  logic [7:0] exp_cnt;
  int         cyc = 0;
  int         mid_cyc = 0;

  logic [7:0] echo_q[$];
  int         echo_cyc_q[$];
  int         mon_state = 0;
  int         mon_cnt = 0;
  int         mon_bit = 0;
  int         mon_start = 0;
  int         mon_err = 0;
  logic [7:0] mon_data = '0;

  uart_echo_unit #(.clock_frequency(CLK_HZ), .baud_rate(BAUD)) dut (
    .clk(clk), .rst_n(rst_n), .rx(rx), .tx(tx), .byte_cnt(byte_cnt)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Reference receiver on tx, sampling each bit at its middle.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      mon_state = 0;
    end else if (mon_state == 0) begin
      if (tx === 1'b0) begin
        mon_state = 1;
        mon_cnt   = B / 2;
        mon_bit   = 0;
        mon_start = cyc;
      end
    end else begin
      mon_cnt--;
      if (mon_cnt == 0) begin
        if (mon_bit == 0) begin
          if (tx !== 1'b0) begin
            mon_err++;
            mon_state = 0;
          end
        end else if (mon_bit <= 8) begin
          mon_data = {tx, mon_data[7:1]};
        end else begin
          if (tx !== 1'b1) mon_err++;
          echo_q.push_back(mon_data);
          echo_cyc_q.push_back(mon_start);
          mon_state = 0;
        end
        mon_bit++;
        mon_cnt = B;
      end
    end
  end

  initial begin
    #(60000 * 10);
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
    $fatal(1, "timeout");
  end

  task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int abort_bit);
    rx = 1'b0;
    repeat (B) @(negedge clk);
    for (int k = 0; k < 8; k++) begin
      rx = b[k];
      if (k == abort_bit) begin
        repeat (B / 2) @(negedge clk);
        return;
      end
      repeat (B) @(negedge clk);
    end
    rx = stop_bit;
    repeat (B / 2) @(negedge clk);
    mid_cyc = cyc;
    repeat (B - B / 2) @(negedge clk);
    rx = 1'b1;
  endtask

  task automatic wait_echoes(input int n);
    for (int i = 0; i < 20 * B && echo_q.size() < n; i++) @(negedge clk);
  endtask

  task automatic clear_echoes();
    echo_q.delete();
    echo_cyc_q.delete();
  endtask

  task automatic test_reset();
    rx    = 1'b1;
    rst_n = 1'b0;
    repeat (5) begin
      @(negedge clk);
      checks++;
      if (tx !== 1'b1) begin errors++; $display("FAIL reset_tx: got %b expected 1", tx); end
      checks++;
      if (byte_cnt !== 8'd0) begin errors++; $display("FAIL reset_cnt: got %0d expected 0", byte_cnt); end
    end
    rst_n   = 1'b1;
    exp_cnt = 8'd0;
    repeat (3 * B) @(negedge clk);
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL release_tx: got %b expected 1", tx); end
    checks++;
    if (byte_cnt !== 8'd0) begin errors++; $display("FAIL release_cnt: got %0d expected 0", byte_cnt); end
  endtask

  task automatic test_single_byte();
    int lat;
    clear_echoes();
    send_frame(8'hAB, 1'b1, -1);
    exp_cnt++;
    wait_echoes(1);
    checks++;
    if (echo_q.size() != 1) begin
      errors++; $display("FAIL single_count: got %0d echoes expected 1", echo_q.size());
    end else begin
      checks++;
      if (echo_q[0] !== 8'hAB) begin errors++; $display("FAIL single_data: got %h expected ab", echo_q[0]); end
      // 2 synchronizer clocks plus at most 2 from the internal stop sample.
      lat = echo_cyc_q[0] - mid_cyc;
      checks++;
      if (lat < 0 || lat > 4) begin errors++; $display("FAIL single_latency: got %0d clocks expected 0..4", lat); end
    end
    checks++;
    if (byte_cnt !== exp_cnt) begin errors++; $display("FAIL single_cnt: got %0d expected %0d", byte_cnt, exp_cnt); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] seq [8];
    seq = '{8'hAB, 8'hCD, 8'hEF, 8'h15, 8'h77, 8'h34, 8'h43, 8'h6B};
    clear_echoes();
    for (int i = 0; i < 8; i++) begin
      send_frame(seq[i], 1'b1, -1);
      exp_cnt++;
    end
    wait_echoes(8);
    checks++;
    if (echo_q.size() != 8) begin
      errors++; $display("FAIL b2b_count: got %0d echoes expected 8", echo_q.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if (echo_q[i] !== seq[i]) begin errors++; $display("FAIL b2b_data[%0d]: got %h expected %h", i, echo_q[i], seq[i]); end
      end
    end
    checks++;
    if (mon_err != 0) begin errors++; $display("FAIL b2b_framing: got %0d errors expected 0", mon_err); end
    checks++;
    if (byte_cnt !== exp_cnt) begin errors++; $display("FAIL b2b_cnt: got %0d expected %0d", byte_cnt, exp_cnt); end
  endtask

  task automatic test_glitch();
    clear_echoes();
    rx = 1'b0;
    repeat (3) @(negedge clk);
    rx = 1'b1;
    repeat (14 * B) @(negedge clk);
    checks++;
    if (echo_q.size() != 0) begin errors++; $display("FAIL glitch_echo: got %0d echoes expected 0", echo_q.size()); end
    checks++;
    if (mon_state != 0) begin errors++; $display("FAIL glitch_tx_busy: got state %0d expected 0", mon_state); end
    checks++;
    if (byte_cnt !== exp_cnt) begin errors++; $display("FAIL glitch_cnt: got %0d expected %0d", byte_cnt, exp_cnt); end
  endtask

  task automatic test_reset_mid_frame();
    clear_echoes();
    send_frame(8'h00, 1'b1, -1);
    exp_cnt++;
    send_frame(8'h22, 1'b1, 4);
    checks++;
    if (tx !== 1'b0) begin errors++; $display("FAIL midrst_pre_tx: got %b expected 0", tx); end
    checks++;
    if (byte_cnt !== exp_cnt) begin errors++; $display("FAIL midrst_pre_cnt: got %0d expected %0d", byte_cnt, exp_cnt); end
    rst_n = 1'b0;
    #1;
    checks++;
    if (tx !== 1'b1) begin errors++; $display("FAIL midrst_tx: got %b expected 1", tx); end
    checks++;
    if (byte_cnt !== 8'd0) begin errors++; $display("FAIL midrst_cnt: got %0d expected 0", byte_cnt); end
    rx = 1'b1;
    repeat (3) @(negedge clk);
    rst_n   = 1'b1;
    exp_cnt = 8'd0;
    repeat (2 * B) @(negedge clk);
    clear_echoes();
    send_frame(8'h5A, 1'b1, -1);
    exp_cnt++;
    wait_echoes(1);
    checks++;
    if (echo_q.size() != 1) begin
      errors++; $display("FAIL midrst_echo_count: got %0d expected 1", echo_q.size());
    end else begin
      checks++;
      if (echo_q[0] !== 8'h5A) begin errors++; $display("FAIL midrst_echo: got %h expected 5a", echo_q[0]); end
    end
    checks++;
    if (byte_cnt !== 8'd1) begin errors++; $display("FAIL midrst_after_cnt: got %0d expected 1", byte_cnt); end
  endtask

  task automatic test_wrap();
    int bad;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n   = 1'b1;
    exp_cnt = 8'd0;
    repeat (B) @(negedge clk);
    clear_echoes();
    for (int i = 0; i < 256; i++) begin
      send_frame(i[7:0], 1'b1, -1);
      exp_cnt++;
      if (i == 254) begin
        checks++;
        if (byte_cnt !== 8'd255) begin errors++; $display("FAIL wrap_255: got %0d expected 255", byte_cnt); end
      end
    end
    checks++;
    if (byte_cnt !== 8'd0) begin errors++; $display("FAIL wrap_0: got %0d expected 0", byte_cnt); end
    wait_echoes(256);
    checks++;
    if (echo_q.size() != 256) begin errors++; $display("FAIL wrap_echo_count: got %0d expected 256", echo_q.size()); end
    bad = 0;
    for (int k = 0; k < echo_q.size() && k < 256; k++)
      if (echo_q[k] !== k[7:0]) bad++;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL wrap_echo_data: got %0d wrong bytes expected 0", bad); end
    checks++;
    if (mon_err != 0) begin errors++; $display("FAIL wrap_framing: got %0d errors expected 0", mon_err); end
  endtask

  task automatic test_framing();
    clear_echoes();
    send_frame(8'h3C, 1'b0, -1);
    repeat (14 * B) @(negedge clk);
`ifdef UART_ECHO_FRAME_CHECK_EN
    checks++;
    if (echo_q.size() != 0) begin errors++; $display("FAIL frame_bad_echo: got %0d echoes expected 0", echo_q.size()); end
`else
    exp_cnt++;
    checks++;
    if (echo_q.size() != 1) begin
      errors++; $display("FAIL frame_bad_echo: got %0d echoes expected 1", echo_q.size());
    end else begin
      checks++;
      if (echo_q[0] !== 8'h3C) begin errors++; $display("FAIL frame_bad_data: got %h expected 3c", echo_q[0]); end
    end
`endif
    checks++;
    if (byte_cnt !== exp_cnt) begin errors++; $display("FAIL frame_bad_cnt: got %0d expected %0d", byte_cnt, exp_cnt); end
    clear_echoes();
    send_frame(8'hC3, 1'b1, -1);
    exp_cnt++;
    wait_echoes(1);
    checks++;
    if (echo_q.size() != 1) begin
      errors++; $display("FAIL frame_next_echo: got %0d echoes expected 1", echo_q.size());
    end else begin
      checks++;
      if (echo_q[0] !== 8'hC3) begin errors++; $display("FAIL frame_next_data: got %h expected c3", echo_q[0]); end
    end
    checks++;
    if (byte_cnt !== exp_cnt) begin errors++; $display("FAIL frame_next_cnt: got %0d expected %0d", byte_cnt, exp_cnt); end
  endtask

  initial begin
    rx    = 1'b1;
    rst_n = 1'b0;
    test_reset();
    test_single_byte();
    test_back_to_back();
    test_glitch();
    test_reset_mid_frame();
    test_wrap();
    test_framing();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_echo_unit.md
Name: uart_echo_unit

Overview:
- Self-contained UART loopback block.
- Receives 8N1 serial bytes on rx and retransmits each byte unchanged on tx.
- Counts the bytes it has received.
- Sits at the board edge as a host-link sanity/bring-up block; contains its own receiver, one-byte holding buffer and transmitter.

Parameters:
- clock_frequency, 12000000, clk frequency in Hz.
- baud_rate, 9600, serial bit rate.
- Bit period is BIT_CLKS = clock_frequency / baud_rate, integer division (default 1250 clocks).

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- rx  input  1  serial input; idle high; asynchronous to clk.
- tx  output  1  serial output; idle high.
- byte_cnt  output  8  count of bytes accepted by the receiver.

Behaviour:
- Reset: asynchronous assert, synchronous release. While rst_n=0: tx=1, byte_cnt=0, buffer empty, rx and tx state machines in IDLE, all counters cleared. Reset mid-frame abandons any partial rx or tx frame; tx returns high immediately.
- Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1). No parity.
- rx input: passes through a 2-flop synchronizer before any use.
- Receiver FSM, states RX_IDLE -> RX_START -> RX_DATA -> RX_STOP -> RX_IDLE:
  - RX_IDLE: waits for a synchronized falling edge (1 -> 0).
  - RX_START: re-samples at BIT_CLKS/2. If the line is high again, treat it as a glitch and return to RX_IDLE with no count.
  - RX_DATA: samples bits 0..7 at the middle of each bit, BIT_CLKS apart.
  - RX_STOP: samples the stop bit at its middle. The byte is accepted in this cycle regardless of the stop-bit value (without the optional feature). Then returns to RX_IDLE, so it can detect a new start edge from mid-stop-bit onward.
- On acceptance:
  - byte_cnt increments by 1, modulo 256 (255 -> 0).
  - The byte is written to the holding buffer.
  - If the buffer is already full, the new byte is dropped (not echoed), but byte_cnt still increments.
- Transmitter FSM, states TX_IDLE -> TX_START -> TX_DATA -> TX_STOP -> TX_IDLE; each bit lasts exactly BIT_CLKS clocks.
  - In TX_IDLE with the buffer full: load the shift register, free the buffer, and drive the start bit on the next clock.
  - Echo latency: the tx start bit begins at most 2 clocks after the rx stop-bit sample point.
- Simultaneous events: a buffer write and buffer read in the same cycle leave the buffer holding the new byte.
- Throughput: the shift register plus holding buffer give double buffering, so continuous back-to-back frames at the same baud rate echo without loss.
- tx is driven from a register; no combinational path from rx to tx.

Optional Feature:
- Macro UART_ECHO_FRAME_CHECK_EN.
- Defined: a byte whose stop bit samples 0 is discarded. It is not counted, not echoed, and the buffer is unaffected. The receiver then waits for the line to return high before re-arming in RX_IDLE.
- Not defined: the stop-bit value is ignored and every completed frame is accepted.

Test Plan:
- Reset: hold rst_n=0 for 5 clocks -> tx=1 and byte_cnt=0 throughout. Release -> tx stays 1 with rx idle.
- Single byte: send 0xAB at 9600 baud with the 12 MHz clock -> tx emits the 0xAB frame starting within 2 clocks of the rx stop-bit midpoint; byte_cnt=1.
- Back-to-back sequence: send AB, CD, EF, 15, 77, 34, 43, 6B through a reference UART with no inter-frame gap -> same 8 bytes echoed in order with no loss; byte_cnt=8; the reference receiver reports no error.
- Glitch rejection: pulse rx low for 400 clocks (< BIT_CLKS/2) -> no echo; byte_cnt unchanged.
- Reset mid-frame: assert rst_n during data bit 4 of an incoming byte and of an outgoing echo -> tx=1 immediately; byte_cnt=0; the next full frame 0x5A after release is echoed correctly with byte_cnt=1.
- Wrap and framing:
  - Send 256 bytes -> byte_cnt returns to 0.
  - With UART_ECHO_FRAME_CHECK_EN, send 0x3C with stop bit 0 -> no echo and count unchanged.
  - Without the macro, the same frame -> 0x3C echoed and count +1.
